// File: rtl/fir_pkg.sv
// Shared types and reset coefficient set for the symmetric FIR filter.
// The default table is listed from the outermost tap pair inward, centre tap last.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } fir_state_e;

    localparam int DEFAULT_NUM = 16;

    localparam logic [7:0] DEFAULT_COEF [DEFAULT_NUM] = '{
        8'd3,  8'd4,  8'd6,  8'd8,  8'd12, 8'd17, 8'd23, 8'd29,
        8'd36, 8'd43, 8'd50, 8'd56, 8'd61, 8'd65, 8'd67, 8'd68
    };

    function automatic logic [7:0] default_coef(input int i);
        logic [7:0] c;
        c = 8'd0;
        if (i >= 0 && i < DEFAULT_NUM) begin
            c = DEFAULT_COEF[i[3:0]];
        end
        return c;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Unique-coefficient register file: reset loads the default low-pass set,
// writes land only while the filter is idle, and the read port is combinational.
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int NUNIQ  = 16,
    parameter int COEF_W = 8,
    parameter int AW     = $clog2(NUNIQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              idle_i,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [COEF_W-1:0] data_i,
    input  logic [AW-1:0]     rd_idx_i,
    output logic [COEF_W-1:0] rd_coef_o
);

    logic [COEF_W-1:0] c_q [NUNIQ];
    logic [COEF_W-1:0] c_d [NUNIQ];

    // Addresses at or above NUNIQ match no entry and are dropped.
    always_comb begin
        for (int i = 0; i < NUNIQ; i++) begin
            c_d[i] = c_q[i];
            if (idle_i && we_i && (addr_i == AW'(i))) begin
                c_d[i] = data_i;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUNIQ; i++) begin
                c_q[i] <= COEF_W'(default_coef(i));
            end
        end else begin
            for (int i = 0; i < NUNIQ; i++) begin
                c_q[i] <= c_d[i];
            end
        end
    end

    assign rd_coef_o = c_q[rd_idx_i];

endmodule

// File: rtl/fir_mac_filter.sv
// Symmetric FIR with one shared multiplier: each accepted sample is folded
// one tap pair per clock into an accumulator, then shifted and saturated.
module fir_mac_filter
    import fir_pkg::*;
#(
    parameter  int DATA_W     = 10,
    parameter  int COEF_W     = 8,
    parameter  int TAPS       = 31,
    parameter  int FRAC_SHIFT = 10,
    localparam int NUNIQ      = (TAPS + 1) / 2,
    localparam int AW         = $clog2(NUNIQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_sample,
    output logic              in_ready,
    input  logic              coef_we,
    input  logic [AW-1:0]     coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_sample,
    output logic              overrun,
    output logic [1:0]        dbg_state_o
);

    localparam int TIW    = $clog2(TAPS);
    localparam int PSUM_W = DATA_W + 1;
    localparam int PROD_W = DATA_W + 1 + COEF_W;
    localparam int ACC_W  = PROD_W + $clog2(NUNIQ);

    fir_state_e state_q, state_d;

    logic accept;
    logic accum_en;
    logic out_en;
    logic last_idx;

    logic [DATA_W-1:0] v_q [TAPS];
    logic [DATA_W-1:0] v_d [TAPS];
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_sample_q, out_sample_d;
    logic              overrun_q, overrun_d;

    logic [COEF_W-1:0] coef;
    logic [TIW-1:0]    near_idx;
    logic [TIW-1:0]    far_idx;
    logic [DATA_W-1:0] near_val;
    logic [DATA_W-1:0] far_val;
    logic [PSUM_W-1:0] pair_sum;
    logic [PROD_W-1:0] product;
    logic [ACC_W-1:0]  shifted;
    logic [DATA_W-1:0] sat_val;

    assign last_idx = (idx_q == AW'(NUNIQ - 1));

    // Handshake: a sample transfers on any edge where in_valid and in_ready are
    // both high; in_ready depends only on the state register, and in_valid
    // while in_ready is low loses the sample and latches overrun.

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = ACCUM;
            ACCUM:   if (last_idx) state_d = OUTPUT;
            OUTPUT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        accum_en = 1'b0;
        out_en   = 1'b0;
        case (state_q)
            IDLE:    in_ready = 1'b1;
            ACCUM:   accum_en = 1'b1;
            OUTPUT:  out_en   = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept      = in_ready & in_valid;
    assign dbg_state_o = state_q;

    fir_coef_bank #(
        .NUNIQ  (NUNIQ),
        .COEF_W (COEF_W),
        .AW     (AW)
    ) u_coef_bank (
        .clk       (clk),
        .reset     (reset),
        .idle_i    (in_ready),
        .we_i      (coef_we),
        .addr_i    (coef_addr),
        .data_i    (coef_data),
        .rd_idx_i  (idx_q),
        .rd_coef_o (coef)
    );

    always_comb begin
        for (int i = 0; i < TAPS; i++) begin
            v_d[i] = v_q[i];
        end
        if (accept) begin
            v_d[0] = in_sample;
            for (int i = 1; i < TAPS; i++) begin
                v_d[i] = v_q[i-1];
            end
        end
    end

    // The centre tap has no mirror partner, so its second operand is forced to zero.
    assign near_idx = TIW'(idx_q);
    assign far_idx  = TIW'(TAPS - 1) - TIW'(idx_q);
    assign near_val = v_q[near_idx];
    assign far_val  = last_idx ? '0 : v_q[far_idx];
    assign pair_sum = PSUM_W'(near_val) + PSUM_W'(far_val);
    assign product  = PROD_W'(coef) * PROD_W'(pair_sum);

    assign shifted  = acc_q >> FRAC_SHIFT;
    assign sat_val  = (|shifted[ACC_W-1:DATA_W]) ? '1 : shifted[DATA_W-1:0];

    always_comb begin
        acc_d = acc_q;
        idx_d = idx_q;
        if (accept) begin
            acc_d = '0;
            idx_d = '0;
        end else if (accum_en) begin
            acc_d = acc_q + ACC_W'(product);
            idx_d = idx_q + AW'(1);
        end
    end

    always_comb begin
        out_valid_d  = out_en;
        out_sample_d = out_en ? sat_val : out_sample_q;
        overrun_d    = overrun_q | (in_valid & ~in_ready);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                v_q[i] <= '0;
            end
            acc_q        <= '0;
            idx_q        <= '0;
            out_valid_q  <= 1'b0;
            out_sample_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            for (int i = 0; i < TAPS; i++) begin
                v_q[i] <= v_d[i];
            end
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            out_valid_q  <= out_valid_d;
            out_sample_q <= out_sample_d;
            overrun_q    <= overrun_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_sample = out_sample_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_fir_mac_filter.sv
// Directed bench for fir_mac_filter: a tap-sum model predicts every output
// and its cycle, and literal values pin the model to hand arithmetic.
module tb_fir_mac_filter;
    import fir_pkg::*;

    localparam int DATA_W = 10;
    localparam int COEF_W = 8;
    localparam int TAPS   = 31;
    localparam int NUNIQ  = 16;
    localparam int AW     = 4;
    localparam int LAT    = NUNIQ + 1;
    localparam int LIMIT  = 200;

    localparam int DEF [NUNIQ] = '{3, 4, 6, 8, 12, 17, 23, 29, 36, 43, 50, 56, 61, 65, 67, 68};

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_sample = '0;
    logic              coef_we = 1'b0;
    logic [AW-1:0]     coef_addr = '0;
    logic [COEF_W-1:0] coef_data = '0;
    wire               in_ready;
    wire               out_valid;
    wire  [DATA_W-1:0] out_sample;
    wire               overrun;
    wire  [1:0]        dbg_state;

    fir_mac_filter dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_sample   (in_sample),
        .in_ready    (in_ready),
        .coef_we     (coef_we),
        .coef_addr   (coef_addr),
        .coef_data   (coef_data),
        .out_valid   (out_valid),
        .out_sample  (out_sample),
        .overrun     (overrun),
        .dbg_state_o (dbg_state)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
        end
    endtask

    // model state
    int unsigned       mv [TAPS];
    int unsigned       mc [NUNIQ];
    int                e = 0;
    int                busy_until = 0;
    logic              m_overrun = 1'b0;
    logic              started = 1'b0;
    logic [DATA_W-1:0] exp_q [$];
    int                due_q [$];
    logic [DATA_W-1:0] exp_last = '0;
    int                last_acc_e = 0;
    int                last_out_e = 0;
    logic [DATA_W-1:0] out_log [$];

    function automatic logic [DATA_W-1:0] model_out();
        longint sum = 0;
        for (int t = 0; t < TAPS; t++) begin
            int k;
            k = (t < NUNIQ) ? t : TAPS - 1 - t;
            sum += longint'(mc[k]) * longint'(mv[t]);
        end
        sum = sum >> 10;
        return (sum > 1023) ? 10'h3ff : sum[DATA_W-1:0];
    endfunction

    // Model: idle when the previous edge number has reached busy_until.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int t = 0; t < TAPS; t++) mv[t] = 0;
            for (int i = 0; i < NUNIQ; i++) mc[i] = DEF[i];
            busy_until = 0;
            exp_q.delete();
            due_q.delete();
            exp_last = '0;
            m_overrun = 1'b0;
        end else begin
            e++;
            if (e - 1 >= busy_until) begin
                if (coef_we && int'(coef_addr) < NUNIQ) mc[coef_addr] = coef_data;
                if (in_valid) begin
                    for (int t = TAPS - 1; t > 0; t--) mv[t] = mv[t-1];
                    mv[0] = in_sample;
                    exp_q.push_back(model_out());
                    due_q.push_back(e + LAT);
                    busy_until = e + LAT;
                    last_acc_e = e;
                end
            end else if (in_valid) begin
                m_overrun = 1'b1;
            end
        end
    end

    // scoreboard compare, every cycle
    always @(negedge clk) begin
        logic exp_ready;
        logic exp_valid;
        if (started) begin
            exp_ready = reset || (e >= busy_until);
            exp_valid = !reset && (due_q.size() > 0) && (due_q[0] == e);
            check("in_ready", in_ready, exp_ready);
            check("state_idle", dbg_state == IDLE, exp_ready);
            check("out_valid", out_valid, exp_valid);
            if (exp_valid) begin
                exp_last = exp_q.pop_front();
                void'(due_q.pop_front());
            end
            if (out_valid) begin
                out_log.push_back(out_sample);
                last_out_e = e;
            end
            check("out_sample", out_sample, exp_last);
            check("overrun", overrun, m_overrun);
        end
    end

    // driver tasks
    task automatic send(input int s);
        int n = 0;
        while (!in_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) begin
            total++;
            bad++;
            $display("FAIL send_timeout got=busy want=ready at %0t", $time);
        end
        in_valid = 1'b1;
        in_sample = DATA_W'(s);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((due_q.size() != 0 || e < busy_until) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) begin
            total++;
            bad++;
            $display("FAIL idle_timeout got=busy want=idle at %0t", $time);
        end
        @(negedge clk);
    endtask

    task automatic write_coef(input int a, input int d);
        coef_we = 1'b1;
        coef_addr = AW'(a);
        coef_data = COEF_W'(d);
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        started = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sample", out_sample, 0);
        check("rst_overrun", overrun, 0);
        @(negedge clk);
        reset = 1'b0;

        // impulse response with default coefficients
        out_log.delete();
        send(1023);
        repeat (30) send(0);
        wait_idle();
        check("imp_count", out_log.size(), 31);
        check("imp_0", out_log[0], 2);
        check("imp_1", out_log[1], 3);
        check("imp_2", out_log[2], 5);
        check("imp_3", out_log[3], 7);
        check("imp_4", out_log[4], 11);
        check("imp_centre", out_log[15], 67);
        check("imp_30", out_log[30], 2);

        // DC gain and saturation
        out_log.delete();
        repeat (31) send(512);
        wait_idle();
        check("dc512", out_log[30], 514);
        out_log.delete();
        repeat (31) send(1023);
        wait_idle();
        check("dc1023_sat", out_log[30], 1023);

        // latency and dropped sample
        check("ovr_before", overrun, 0);
        send(100);
        repeat (4) @(negedge clk);
        in_valid = 1'b1;
        in_sample = 10'd777;
        @(negedge clk);
        in_valid = 1'b0;
        check("ovr_after", overrun, 1);
        wait_idle();
        check("latency", last_out_e - last_acc_e, 17);

        // runtime coefficient set: centre only
        for (int a = 0; a < NUNIQ - 1; a++) write_coef(a, 0);
        write_coef(NUNIQ - 1, 255);
        repeat (31) send(0);
        wait_idle();
        out_log.delete();
        send(1000);
        repeat (30) send(0);
        wait_idle();
        check("cw_count", out_log.size(), 31);
        check("cw_0", out_log[0], 0);
        check("cw_centre", out_log[15], 249);
        check("cw_30", out_log[30], 0);

        // write during ACCUM is ignored
        send(0);
        write_coef(NUNIQ - 1, 0);
        wait_idle();
        out_log.delete();
        send(1000);
        repeat (15) send(0);
        wait_idle();
        check("accum_write_ignored", out_log[15], 249);

        // write together with an accepted sample takes effect for that sample
        out_log.delete();
        in_valid = 1'b1;
        in_sample = 10'd1000;
        coef_we = 1'b1;
        coef_addr = 4'd0;
        coef_data = 8'd200;
        @(negedge clk);
        in_valid = 1'b0;
        coef_we = 1'b0;
        wait_idle();
        check("same_edge_write", out_log[0], 195);

        // reset in the middle of ACCUM
        send(5);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_sample", out_sample, 0);
        check("mid_rst_overrun", overrun, 0);
        reset = 1'b0;
        out_log.delete();
        repeat (25) @(negedge clk);
        check("no_aborted_pulse", out_log.size(), 0);
        send(1023);
        wait_idle();
        check("post_rst_default", out_log[0], 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
